mem_dispatch: RTL and testbench

MEM_DISPATCH -- requirements
Module: mem_dispatch

---
 rtl/mem_dispatch_if.sv | 87 ++++++++
 rtl/mem_dispatch.sv | 122 ++++++++++++
 tb/tb_mem_dispatch.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dispatch_if.sv
// LSU-facing request/response bundle plus the CLINT and system-bus request ports.
// slave is the dispatcher's view; master is the LSU/downstream environment's view.
interface mem_dispatch_if;
  logic        mem_dispatch_lsu_valid_i;
  logic        mem_dispatch_lsu_req_i;
  logic [63:0] mem_dispatch_lsu_addr_i;
  logic [1:0]  mem_dispatch_lsu_size_i;
  logic [63:0] mem_dispatch_lsu_data_write_i;
  logic        mem_dispatch_lsu_ready_o;
  logic        mem_dispatch_lsu_done_o;
  logic [63:0] mem_dispatch_lsu_data_read_o;
  logic [1:0]  mem_dispatch_lsu_resp_o;

  logic        mem_dispatch_clint_valid_o;
  logic        mem_dispatch_clint_req_o;
  logic [63:0] mem_dispatch_clint_addr_o;
  logic [1:0]  mem_dispatch_clint_size_o;
  logic [63:0] mem_dispatch_clint_data_write_o;
  logic        mem_dispatch_clint_ready_i;
  logic [63:0] mem_dispatch_clint_data_read_i;
  logic [1:0]  mem_dispatch_clint_resp_i;

  logic        mem_dispatch_bus_valid_o;
  logic        mem_dispatch_bus_req_o;
  logic [63:0] mem_dispatch_bus_addr_o;
  logic [1:0]  mem_dispatch_bus_size_o;
  logic [63:0] mem_dispatch_bus_data_write_o;
  logic        mem_dispatch_bus_ready_i;
  logic [63:0] mem_dispatch_bus_data_read_i;
  logic [1:0]  mem_dispatch_bus_resp_i;

  modport slave (
    input  mem_dispatch_lsu_valid_i,
    input  mem_dispatch_lsu_req_i,
    input  mem_dispatch_lsu_addr_i,
    input  mem_dispatch_lsu_size_i,
    input  mem_dispatch_lsu_data_write_i,
    output mem_dispatch_lsu_ready_o,
    output mem_dispatch_lsu_done_o,
    output mem_dispatch_lsu_data_read_o,
    output mem_dispatch_lsu_resp_o,
    output mem_dispatch_clint_valid_o,
    output mem_dispatch_clint_req_o,
    output mem_dispatch_clint_addr_o,
    output mem_dispatch_clint_size_o,
    output mem_dispatch_clint_data_write_o,
    input  mem_dispatch_clint_ready_i,
    input  mem_dispatch_clint_data_read_i,
    input  mem_dispatch_clint_resp_i,
    output mem_dispatch_bus_valid_o,
    output mem_dispatch_bus_req_o,
    output mem_dispatch_bus_addr_o,
    output mem_dispatch_bus_size_o,
    output mem_dispatch_bus_data_write_o,
    input  mem_dispatch_bus_ready_i,
    input  mem_dispatch_bus_data_read_i,
    input  mem_dispatch_bus_resp_i
  );

  modport master (
    output mem_dispatch_lsu_valid_i,
    output mem_dispatch_lsu_req_i,
    output mem_dispatch_lsu_addr_i,
    output mem_dispatch_lsu_size_i,
    output mem_dispatch_lsu_data_write_i,
    input  mem_dispatch_lsu_ready_o,
    input  mem_dispatch_lsu_done_o,
    input  mem_dispatch_lsu_data_read_o,
    input  mem_dispatch_lsu_resp_o,
    input  mem_dispatch_clint_valid_o,
    input  mem_dispatch_clint_req_o,
    input  mem_dispatch_clint_addr_o,
    input  mem_dispatch_clint_size_o,
    input  mem_dispatch_clint_data_write_o,
    output mem_dispatch_clint_ready_i,
    output mem_dispatch_clint_data_read_i,
    output mem_dispatch_clint_resp_i,
    input  mem_dispatch_bus_valid_o,
    input  mem_dispatch_bus_req_o,
    input  mem_dispatch_bus_addr_o,
    input  mem_dispatch_bus_size_o,
    input  mem_dispatch_bus_data_write_o,
    output mem_dispatch_bus_ready_i,
    output mem_dispatch_bus_data_read_i,
    output mem_dispatch_bus_resp_i
  );
endinterface

// File: rtl/mem_dispatch.sv
// Routes one LSU access at a time to the CLINT or the system bus,
// flags misaligned accesses locally and returns a one-cycle done pulse.
module mem_dispatch #(
  parameter logic [63:0] CLINT_BASE = 64'h0000_0000_0200_0000,
  parameter logic [63:0] CLINT_SIZE = 64'h0000_0000_0001_0000
) (
  input logic           clk,
  input logic           rst,
  mem_dispatch_if.slave io
);
  typedef enum logic [1:0] {
    IDLE,
    CLINT,
    BUS,
    DONE
  } state_t;

  // 65-bit end so a window touching 2^64 cannot wrap
  localparam logic [64:0] CLINT_END =
    {1'b0, CLINT_BASE} + {1'b0, CLINT_SIZE};

  state_t      state, state_nx;
  logic        req_q;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic [1:0]  resp_q;

  logic        ready;
  logic        accept;
  logic        misal;
  logic        in_clint;

  assign accept = io.mem_dispatch_lsu_valid_i & ready;

  assign in_clint =
    (io.mem_dispatch_lsu_addr_i >= CLINT_BASE) &&
    ({1'b0, io.mem_dispatch_lsu_addr_i} < CLINT_END);

  always_comb begin
    misal = 1'b0;
    unique case (io.mem_dispatch_lsu_size_i)
      2'd0: misal = 1'b0;
      2'd1: misal = io.mem_dispatch_lsu_addr_i[0];
      2'd2: misal = |io.mem_dispatch_lsu_addr_i[1:0];
      2'd3: misal = |io.mem_dispatch_lsu_addr_i[2:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (misal)         state_nx = DONE;
          else if (in_clint) state_nx = CLINT;
          else               state_nx = BUS;
        end
      end
      CLINT: if (io.mem_dispatch_clint_ready_i) state_nx = DONE;
      BUS:   if (io.mem_dispatch_bus_ready_i)   state_nx = DONE;
      DONE:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE) & ~rst;
    io.mem_dispatch_lsu_ready_o   = ready;
    io.mem_dispatch_lsu_done_o    = (state == DONE);
    io.mem_dispatch_clint_valid_o = (state == CLINT);
    io.mem_dispatch_bus_valid_o   = (state == BUS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      if (accept) begin
        req_q   <= io.mem_dispatch_lsu_req_i;
        addr_q  <= io.mem_dispatch_lsu_addr_i;
        size_q  <= io.mem_dispatch_lsu_size_i;
        wdata_q <= io.mem_dispatch_lsu_data_write_i;
        if (misal) begin
          rdata_q <= '0;
          resp_q  <= 2'b10;
        end
      end
      if (state == CLINT && io.mem_dispatch_clint_ready_i) begin
        rdata_q <= req_q ? '0 : io.mem_dispatch_clint_data_read_i;
        resp_q  <= io.mem_dispatch_clint_resp_i;
      end
      if (state == BUS && io.mem_dispatch_bus_ready_i) begin
        rdata_q <= req_q ? '0 : io.mem_dispatch_bus_data_read_i;
        resp_q  <= io.mem_dispatch_bus_resp_i;
      end
    end
  end

  assign io.mem_dispatch_lsu_data_read_o = rdata_q;
  assign io.mem_dispatch_lsu_resp_o      = resp_q;

  assign io.mem_dispatch_clint_req_o        = req_q;
  assign io.mem_dispatch_clint_addr_o       = addr_q;
  assign io.mem_dispatch_clint_size_o       = size_q;
  assign io.mem_dispatch_clint_data_write_o = wdata_q;

  assign io.mem_dispatch_bus_req_o        = req_q;
  assign io.mem_dispatch_bus_addr_o       = addr_q;
  assign io.mem_dispatch_bus_size_o       = size_q;
  assign io.mem_dispatch_bus_data_write_o = wdata_q;
endmodule

// File: tb/tb_mem_dispatch.sv
// Bench for mem_dispatch: directed vector table, hand sequences for
// reset/back-to-back corners, and random traffic against a reference model.
module tb_mem_dispatch;
  localparam logic [63:0] CB = 64'h0000_0000_0200_0000;
  localparam logic [63:0] CS = 64'h0000_0000_0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mem_dispatch_if io();

  mem_dispatch #(.CLINT_BASE(CB), .CLINT_SIZE(CS)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rq;
    logic [63:0] ad;
    logic [1:0]  sz;
    logic [63:0] wd;
    logic [63:0] dd;
    logic [1:0]  dr;
    int          etgt;
    logic [63:0] erd;
    logic [1:0]  ers;
    int          elat;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: target 0 none, 1 CLINT, 2 bus; latency in cycles from accept
  function automatic void model(
    input logic rq, input logic [63:0] ad, input logic [1:0] sz,
    input logic [63:0] dd, input logic [1:0] dr, input int wt,
    output int tgt, output logic [63:0] rd, output logic [1:0] rs,
    output int lat);
    logic [63:0] al;
    bit mis, inc;
    al  = 64'd1 << sz;
    mis = (ad % al) != 0;
    inc = (ad >= CB) && ((ad - CB) < CS);
    if (mis) begin
      tgt = 0; rd = '0; rs = 2'b10; lat = 1;
    end else begin
      tgt = inc ? 1 : 2;
      rd  = rq ? 64'd0 : dd;
      rs  = dr;
      lat = 2 + wt;
    end
  endfunction

  task automatic idle_inputs();
    io.mem_dispatch_lsu_valid_i       = 1'b0;
    io.mem_dispatch_lsu_req_i         = 1'b0;
    io.mem_dispatch_lsu_addr_i        = '0;
    io.mem_dispatch_lsu_size_i        = '0;
    io.mem_dispatch_lsu_data_write_i  = '0;
    io.mem_dispatch_clint_ready_i     = 1'b0;
    io.mem_dispatch_clint_data_read_i = '0;
    io.mem_dispatch_clint_resp_i      = '0;
    io.mem_dispatch_bus_ready_i       = 1'b0;
    io.mem_dispatch_bus_data_read_i   = '0;
    io.mem_dispatch_bus_resp_i        = '0;
  endtask

  task automatic run_txn(
    input logic rq, input logic [63:0] ad, input logic [1:0] sz,
    input logic [63:0] wd, input logic [63:0] dd, input logic [1:0] dr,
    input int wt, input bit noise,
    output int tgt, output logic [63:0] rd, output logic [1:0] rs,
    output int lat);
    int  n;
    int  bad;
    bit  got;
    tgt = 0; rd = '0; rs = '0; lat = -1;
    n = 0; bad = 0; got = 0;
    io.mem_dispatch_lsu_valid_i      = 1'b1;
    io.mem_dispatch_lsu_req_i        = rq;
    io.mem_dispatch_lsu_addr_i       = ad;
    io.mem_dispatch_lsu_size_i       = sz;
    io.mem_dispatch_lsu_data_write_i = wd;
    chk("accept_ready", 64'(io.mem_dispatch_lsu_ready_o), 64'd1);
    step();
    io.mem_dispatch_lsu_valid_i      = 1'b0;
    io.mem_dispatch_lsu_req_i        = ~rq;
    io.mem_dispatch_lsu_addr_i       = ~ad;
    io.mem_dispatch_lsu_size_i       = ~sz;
    io.mem_dispatch_lsu_data_write_i = ~wd;
    for (int c = 1; c < 60 && !got; c++) begin
      if (io.mem_dispatch_lsu_done_o) begin
        got = 1; lat = c;
        rd = io.mem_dispatch_lsu_data_read_o;
        rs = io.mem_dispatch_lsu_resp_o;
      end else begin
        if (io.mem_dispatch_lsu_ready_o) bad++;
        if (io.mem_dispatch_clint_valid_o && io.mem_dispatch_bus_valid_o)
          bad++;
        else if (io.mem_dispatch_clint_valid_o) begin
          if (tgt == 0) tgt = 1;
          if (tgt != 1) bad++;
          if (io.mem_dispatch_clint_req_o !== rq ||
              io.mem_dispatch_clint_addr_o !== ad ||
              io.mem_dispatch_clint_size_o !== sz ||
              io.mem_dispatch_clint_data_write_o !== wd) bad++;
        end else if (io.mem_dispatch_bus_valid_o) begin
          if (tgt == 0) tgt = 2;
          if (tgt != 2) bad++;
          if (io.mem_dispatch_bus_req_o !== rq ||
              io.mem_dispatch_bus_addr_o !== ad ||
              io.mem_dispatch_bus_size_o !== sz ||
              io.mem_dispatch_bus_data_write_o !== wd) bad++;
        end else bad++;
        n++;
        io.mem_dispatch_clint_ready_i = 1'b0;
        io.mem_dispatch_bus_ready_i   = 1'b0;
        if (tgt == 1) begin
          io.mem_dispatch_clint_ready_i     = (n > wt);
          io.mem_dispatch_clint_data_read_i = dd;
          io.mem_dispatch_clint_resp_i      = dr;
          io.mem_dispatch_bus_ready_i       = noise & $urandom_range(1, 0);
          io.mem_dispatch_bus_data_read_i   = {$urandom, $urandom};
          io.mem_dispatch_bus_resp_i        = 2'($urandom);
        end else if (tgt == 2) begin
          io.mem_dispatch_bus_ready_i       = (n > wt);
          io.mem_dispatch_bus_data_read_i   = dd;
          io.mem_dispatch_bus_resp_i        = dr;
          io.mem_dispatch_clint_ready_i     = noise & $urandom_range(1, 0);
          io.mem_dispatch_clint_data_read_i = {$urandom, $urandom};
          io.mem_dispatch_clint_resp_i      = 2'($urandom);
        end
        step();
      end
    end
    idle_inputs();
    chk("txn_invariants", 64'(bad), 64'd0);
    step();
    chk("pulse_end", {62'd0, io.mem_dispatch_lsu_done_o,
                      io.mem_dispatch_lsu_ready_o}, 64'd1);
  endtask

  task automatic apply(input string nm, input vec_t v, input int wt,
                       input bit noise);
    int          tgt, lat;
    logic [63:0] rd;
    logic [1:0]  rs;
    run_txn(v.rq, v.ad, v.sz, v.wd, v.dd, v.dr, wt, noise,
            tgt, rd, rs, lat);
    chk({nm, "_target"}, 64'(tgt), 64'(v.etgt));
    chk({nm, "_latency"}, 64'(lat), 64'(v.elat));
    chk({nm, "_data"}, rd, v.erd);
    chk({nm, "_resp"}, 64'(rs), 64'(v.ers));
    chk({nm, "_hold"}, io.mem_dispatch_lsu_data_read_o, v.erd);
  endtask

  initial begin
    vec_t v;
    int   acc[$];
    int   dn[$];
    vt[0]  = '{1'b0, 64'h0200_BFF8, 2'd3, 64'h0, 64'h1234, 2'b00,
               1, 64'h1234, 2'b00, 2};
    vt[1]  = '{1'b0, 64'h8000_0004, 2'd3, 64'h0, 64'h5555, 2'b00,
               0, 64'h0, 2'b10, 1};
    vt[2]  = '{1'b0, 64'h0200_FFF8, 2'd3, 64'h0, 64'hAA, 2'b00,
               1, 64'hAA, 2'b00, 2};
    vt[3]  = '{1'b0, 64'h0201_0000, 2'd3, 64'h0, 64'hBB, 2'b01,
               2, 64'hBB, 2'b01, 2};
    vt[4]  = '{1'b0, 64'h01FF_FFF8, 2'd3, 64'h0, 64'hCC, 2'b00,
               2, 64'hCC, 2'b00, 2};
    vt[5]  = '{1'b1, 64'h0200_4000, 2'd2, 64'h5, 64'h77, 2'b00,
               1, 64'h0, 2'b00, 2};
    vt[6]  = '{1'b0, 64'h8000_0001, 2'd1, 64'h0, 64'h66, 2'b00,
               0, 64'h0, 2'b10, 1};
    vt[7]  = '{1'b0, 64'h8000_0003, 2'd0, 64'h0, 64'h5A, 2'b11,
               2, 64'h5A, 2'b11, 2};
    vt[8]  = '{1'b1, 64'h8000_0002, 2'd2, 64'h9, 64'h0, 2'b00,
               0, 64'h0, 2'b10, 1};
    vt[9]  = '{1'b0, 64'h0200_0000, 2'd0, 64'h0, 64'h11, 2'b10,
               1, 64'h11, 2'b10, 2};
    vt[10] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 64'h0, 64'h99,
               2'b00, 2, 64'h99, 2'b00, 2};

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_ready", 64'(io.mem_dispatch_lsu_ready_o), 64'd0);
    chk("rst_outs", {59'd0, io.mem_dispatch_lsu_done_o,
                     io.mem_dispatch_clint_valid_o,
                     io.mem_dispatch_bus_valid_o,
                     io.mem_dispatch_lsu_resp_o}, 64'd0);
    chk("rst_data", io.mem_dispatch_lsu_data_read_o, 64'd0);
    chk("rst_fields", io.mem_dispatch_bus_addr_o ^
                      io.mem_dispatch_clint_data_write_o ^
                      {61'd0, io.mem_dispatch_bus_req_o,
                       io.mem_dispatch_clint_size_o}, 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(io.mem_dispatch_lsu_ready_o), 64'd1);

    for (int i = 0; i < 11; i++)
      apply($sformatf("vec%0d", i), vt[i], 0, 1'b0);

    // Bus write stalled five cycles
    v = '{1'b1, 64'h8000_0000, 2'd2, 64'hDEAD_BEEF, 64'h1, 2'b00,
          2, 64'h0, 2'b00, 7};
    apply("stall5", v, 5, 1'b1);

    // Reset while the bus is still waiting
    io.mem_dispatch_lsu_valid_i = 1'b1;
    io.mem_dispatch_lsu_addr_i  = 64'h8000_0000;
    io.mem_dispatch_lsu_size_i  = 2'd3;
    step();
    io.mem_dispatch_lsu_valid_i = 1'b0;
    chk("midrst_busy", 64'(io.mem_dispatch_bus_valid_o), 64'd1);
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_state", {61'd0, io.mem_dispatch_bus_valid_o,
                         io.mem_dispatch_lsu_done_o,
                         io.mem_dispatch_lsu_ready_o}, 64'd0);
    rst = 1'b0;
    io.mem_dispatch_bus_ready_i     = 1'b1;
    io.mem_dispatch_bus_data_read_i = 64'hFEED;
    step();
    chk("late_ready", {61'd0, io.mem_dispatch_bus_valid_o,
                       io.mem_dispatch_lsu_done_o,
                       io.mem_dispatch_lsu_ready_o}, 64'd1);
    chk("late_data", io.mem_dispatch_lsu_data_read_o, 64'd0);
    idle_inputs();

    // Back-to-back CLINT writes, valid held high
    io.mem_dispatch_lsu_valid_i      = 1'b1;
    io.mem_dispatch_lsu_req_i        = 1'b1;
    io.mem_dispatch_lsu_addr_i       = 64'h0200_4008;
    io.mem_dispatch_lsu_size_i       = 2'd3;
    io.mem_dispatch_lsu_data_write_i = 64'h42;
    io.mem_dispatch_clint_ready_i    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (io.mem_dispatch_lsu_done_o) dn.push_back(c);
      if (io.mem_dispatch_lsu_ready_o && io.mem_dispatch_lsu_valid_i)
        acc.push_back(c);
      step();
      if (acc.size() == 2) io.mem_dispatch_lsu_valid_i = 1'b0;
    end
    idle_inputs();
    chk("b2b_accepts", 64'(acc.size()), 64'd2);
    chk("b2b_dones", 64'(dn.size()), 64'd2);
    if (acc.size() == 2 && dn.size() == 2) begin
      chk("b2b_accept_gap", 64'(acc[1] - dn[0]), 64'd1);
      chk("b2b_done_gap", 64'(dn[1] - dn[0]), 64'd3);
    end
    step();

    for (int i = 0; i < 60; i++) begin
      int wt;
      case ($urandom_range(3, 0))
        0: v.ad = CB + 64'($urandom_range(32'hFFFF, 0));
        1: v.ad = 64'h8000_0000 + 64'($urandom);
        2: v.ad = {$urandom, $urandom};
        default: v.ad = CB + CS - 64'd8 + 64'($urandom_range(15, 0));
      endcase
      v.sz = 2'($urandom);
      if ($urandom_range(1, 0) == 1)
        v.ad = v.ad & ~((64'd1 << v.sz) - 64'd1);
      v.rq = 1'($urandom);
      v.wd = {$urandom, $urandom};
      v.dd = {$urandom, $urandom};
      v.dr = 2'($urandom);
      wt   = $urandom_range(3, 0);
      model(v.rq, v.ad, v.sz, v.dd, v.dr, wt,
            v.etgt, v.erd, v.ers, v.elat);
      apply($sformatf("rnd%0d", i), v, wt, 1'b1);
      if ($urandom_range(1, 0) == 1) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
